// File: rtl/norm_share_arbiter.sv
// norm_share_arbiter: round-robin share of one combinational normalizer between
// the adder (A) and multiplier (B) paths. Stage 1 holds the granted operand and
// feeds the normalizer; stage 2 registers the normalized result with its tag.
module norm_share_arbiter #(
    parameter int unsigned MW   = 24,
    parameter int unsigned EW   = 8,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic            a_sign,
    input  logic [MW-1:0]   a_mant,
    input  logic [EW-1:0]   a_exp,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic            b_sign,
    input  logic [MW-1:0]   b_mant,
    input  logic [EW-1:0]   b_exp,
    output logic [MW-1:0]   nrm_mant_o,
    output logic [EW-1:0]   nrm_exp_o,
    input  logic [MW-2:0]   nrm_mant_i,
    input  logic [EW-1:0]   nrm_exp_i,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_id,
    output logic            res_sign,
    output logic [MW-2:0]   res_mant,
    output logic [EW-1:0]   res_exp,
    output logic            res_zero,
    output logic [CNTW-1:0] cnt_a,
    output logic [CNTW-1:0] cnt_b
);

    localparam logic [0:0]      StEmpty = 1'b0;
    localparam logic [0:0]      StFull  = 1'b1;
    localparam logic [CNTW-1:0] CntOne  = CNTW'(1);

    logic [0:0]      s1_state_q, s1_state_d;
    logic [0:0]      s2_state_q, s2_state_d;
    logic            s1_full, s2_full;
    logic            s2_adv, s1_free, acc_a, acc_b, res_hs;
    logic            rr_last_q;  // id of the requester served last
    logic            s1_id_q, s1_sign_q;
    logic [MW-1:0]   s1_mant_q;
    logic [EW-1:0]   s1_exp_q;
    logic            res_id_q, res_sign_q, res_zero_q;
    logic [MW-2:0]   res_mant_q;
    logic [EW-1:0]   res_exp_q;
    logic [CNTW-1:0] cnt_a_q, cnt_b_q;

    // Handshakes and arbitration; ready never looks at its own port's valid.
    always_comb begin
        s1_full = (s1_state_q == StFull);
        s2_full = (s2_state_q == StFull);
        s2_adv  = s1_full & (~s2_full | res_ready);
        s1_free = ~s1_full | s2_adv;
        a_ready = s1_free & (~b_valid | rr_last_q);
        b_ready = s1_free & (~a_valid | ~rr_last_q);
        acc_a   = a_valid & a_ready;
        acc_b   = b_valid & b_ready;
        res_hs  = s2_full & res_ready;
    end

    // Stage occupancy next state: a new accept wins over a drain of stage 1.
    always_comb begin
        s1_state_d = s1_state_q;
        s2_state_d = s2_state_q;
        if (acc_a | acc_b) begin
            s1_state_d = StFull;
        end else if (s2_adv) begin
            s1_state_d = StEmpty;
        end
        if (s2_adv) begin
            s2_state_d = StFull;
        end else if (res_hs) begin
            s2_state_d = StEmpty;
        end
    end

    // State registers for both stage FSMs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_state_q <= StEmpty;
            s2_state_q <= StEmpty;
        end else begin
            s1_state_q <= s1_state_d;
            s2_state_q <= s2_state_d;
        end
    end

    // Stage 1 operand capture and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last_q <= 1'b1;
            s1_id_q   <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_mant_q <= '0;
            s1_exp_q  <= '0;
        end else if (acc_a) begin
            rr_last_q <= 1'b0;
            s1_id_q   <= 1'b0;
            s1_sign_q <= a_sign;
            s1_mant_q <= a_mant;
            s1_exp_q  <= a_exp;
        end else if (acc_b) begin
            rr_last_q <= 1'b1;
            s1_id_q   <= 1'b1;
            s1_sign_q <= b_sign;
            s1_mant_q <= b_mant;
            s1_exp_q  <= b_exp;
        end
    end

    // Stage 2 result capture; a zero operand forces a clean zero result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_id_q   <= 1'b0;
            res_sign_q <= 1'b0;
            res_zero_q <= 1'b0;
            res_mant_q <= '0;
            res_exp_q  <= '0;
        end else if (s2_adv) begin
            res_id_q   <= s1_id_q;
            res_sign_q <= s1_sign_q;
            res_zero_q <= (s1_mant_q == '0);
            res_mant_q <= (s1_mant_q == '0) ? '0 : nrm_mant_i;
            res_exp_q  <= (s1_mant_q == '0) ? '0 : nrm_exp_i;
        end
    end

    // Per-requester delivered-result counters, wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else if (res_hs) begin
            if (res_id_q) begin
                cnt_b_q <= cnt_b_q + CntOne;
            end else begin
                cnt_a_q <= cnt_a_q + CntOne;
            end
        end
    end

    assign nrm_mant_o = s1_mant_q;
    assign nrm_exp_o  = s1_exp_q;
    assign res_valid  = s2_full;
    assign res_id     = res_id_q;
    assign res_sign   = res_sign_q;
    assign res_mant   = res_mant_q;
    assign res_exp    = res_exp_q;
    assign res_zero   = res_zero_q;
    assign cnt_a      = cnt_a_q;
    assign cnt_b      = cnt_b_q;

endmodule
